// File: rtl/lcd_timing_driver_if.sv
// Bundles the content-stage handshake and panel pins of the LCD timing driver.
// master = timing driver, slave = content stage / panel side.
interface lcd_timing_driver_if;
    logic [23:0] pixel_data;
    logic        pattern_en;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        lcd_bl;
    logic        lcd_rst;
    logic        frame_start;

    modport master (
        input  pixel_data, pattern_en,
        output pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst, frame_start
    );

    modport slave (
        output pixel_data, pattern_en,
        input  pixel_xpos, pixel_ypos, h_disp, v_disp,
               lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, lcd_rst, frame_start
    );
endinterface

// File: rtl/lcd_timing_driver.sv
// RGB-LCD timing generator/output stage; TIMING_TEST_PATTERN_EN adds 8 colour bars.
// Latency: outputs decode the counters combinationally; pixel_xpos leads lcd_de by 1 cycle.
// Backpressure: none, free-running at lcd_pclk; content stage must answer in 1 cycle.
module lcd_timing_driver #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int H_TOTAL = 525,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2,
    parameter int V_TOTAL = 286
) (
    input  logic                lcd_pclk,
    input  logic                rst_n,
    lcd_timing_driver_if.master lcd
);

    localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_W = 11'(V_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HA       = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] HA_M1    = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] H_END_M1 = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] VA       = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END    = 11'(V_SYNC + V_BACK + V_DISP);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        v_act;
    logic        de;
    logic        data_req;
    logic [23:0] rgb;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign v_act    = (v_cnt >= VA) && (v_cnt < V_END);
    assign de       = v_act && (h_cnt >= HA) && (h_cnt < H_END);
    // One column ahead of de so the content stage's register lines up with it.
    assign data_req = v_act && (h_cnt >= HA_M1) && (h_cnt < H_END_M1);

    assign lcd.lcd_hs      = (h_cnt >= H_SYNC_W);
    assign lcd.lcd_vs      = (v_cnt >= V_SYNC_W);
    assign lcd.lcd_de      = de;
    assign lcd.pixel_xpos  = data_req ? (h_cnt - HA_M1) : 11'd0;
    assign lcd.pixel_ypos  = v_act ? (v_cnt - VA) : 11'd0;
    assign lcd.h_disp      = 11'(H_DISP);
    assign lcd.v_disp      = 11'(V_DISP);
    assign lcd.lcd_bl      = 1'b1;
    assign lcd.lcd_rst     = 1'b1;
    assign lcd.frame_start = (h_cnt == 11'd0) && (v_cnt == 11'd0);

`ifdef TIMING_TEST_PATTERN_EN
    localparam logic [11:0] H_DISP_W12 = 12'(H_DISP);

    // bar_idx = floor(col*8/H_DISP) tracked as quotient/remainder, no divider.
    logic [2:0]  bar_idx;
    logic [11:0] bar_rem;
    logic [11:0] rem_step;
    logic [23:0] bar_rgb;

    assign rem_step = bar_rem + 12'd8;

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx <= '0;
            bar_rem <= '0;
        end else if (h_cnt == HA_M1) begin
            bar_idx <= '0;
            bar_rem <= '0;
        end else if (rem_step >= H_DISP_W12) begin
            bar_idx <= bar_idx + 3'd1;
            bar_rem <= rem_step - H_DISP_W12;
        end else begin
            bar_rem <= rem_step;
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end
`else
    logic unused_pattern_en;
    assign unused_pattern_en = lcd.pattern_en;
`endif

    always_comb begin
        rgb = 24'h000000;
        if (de) begin
            rgb = lcd.pixel_data;
`ifdef TIMING_TEST_PATTERN_EN
            if (lcd.pattern_en) begin
                rgb = bar_rgb;
            end
`endif
        end
    end

    assign lcd.lcd_rgb = rgb;

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver on a 12x7 geometry: per-cycle decode checks plus an rgb scoreboard.
module tb_lcd_timing_driver;

    localparam int H_SYNC  = 2;
    localparam int H_BACK  = 1;
    localparam int H_DISP  = 8;
    localparam int H_FRONT = 1;
    localparam int H_TOTAL = 12;
    localparam int V_SYNC  = 1;
    localparam int V_BACK  = 1;
    localparam int V_DISP  = 4;
    localparam int V_FRONT = 1;
    localparam int V_TOTAL = 7;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;
    localparam int FRAME   = H_TOTAL * V_TOTAL;

    logic lcd_pclk = 1'b0;
    logic rst_n    = 1'b0;

    always #5 lcd_pclk = ~lcd_pclk;

    lcd_timing_driver_if bus ();

    lcd_timing_driver #(
        .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_DISP (H_DISP),
        .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
        .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_DISP (V_DISP),
        .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL)
    ) dut (
        .lcd_pclk(lcd_pclk),
        .rst_n   (rst_n),
        .lcd     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          m_h      = 0;
    int          m_v      = 0;
    int          cyc      = 0;
    int          de_cnt   = 0;
    int          fs_last  = -1;
    int          fs_prev  = -1;
    bit          echo_mode = 1'b1;
    logic [23:0] sb[$];
    logic [23:0] bars[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (h=%0d v=%0d)", tag, obs, exp, m_h, m_v);
        end
    endtask

    // Checks the current (negedge) state against the model, then advances one clock.
    task automatic cycle();
        logic        v_act;
        logic        de;
        logic        req;
        logic [23:0] exp_rgb;
        logic [23:0] exp_push;
        logic [23:0] nxt_pd;
        v_act = (m_v >= VA) && (m_v < VA + V_DISP);
        de    = v_act && (m_h >= HA) && (m_h < HA + H_DISP);
        req   = v_act && (m_h >= HA - 1) && (m_h < HA + H_DISP - 1);

        chk("lcd_hs",      32'(bus.lcd_hs),      32'(m_h >= H_SYNC));
        chk("lcd_vs",      32'(bus.lcd_vs),      32'(m_v >= V_SYNC));
        chk("lcd_de",      32'(bus.lcd_de),      32'(de));
        chk("frame_start", 32'(bus.frame_start), 32'(m_h == 0 && m_v == 0));
        chk("pixel_xpos",  32'(bus.pixel_xpos),  req ? 32'(m_h - (HA - 1)) : 32'd0);
        chk("pixel_ypos",  32'(bus.pixel_ypos),  v_act ? 32'(m_v - VA) : 32'd0);
        chk("lcd_bl",      32'(bus.lcd_bl),      32'd1);
        chk("lcd_rst",     32'(bus.lcd_rst),     32'd1);
        chk("h_disp",      32'(bus.h_disp),      32'(H_DISP));
        chk("v_disp",      32'(bus.v_disp),      32'(V_DISP));

        exp_rgb = 24'h000000;
        if (de) begin
            if (sb.size() == 0) chk("sb_depth", 32'(sb.size()), 32'd1);
            else exp_rgb = sb.pop_front();
        end
        chk("lcd_rgb", 32'(bus.lcd_rgb), 32'(exp_rgb));

        if (req) begin
            exp_push = echo_mode ? 24'(m_h - (HA - 1)) : 24'hABCDEF;
`ifdef TIMING_TEST_PATTERN_EN
            if (bus.pattern_en) exp_push = bars[((m_h - (HA - 1)) * 8) / H_DISP];
`endif
            sb.push_back(exp_push);
        end

        if (bus.lcd_de) de_cnt++;
        if (bus.frame_start && rst_n) begin
            fs_prev = fs_last;
            fs_last = cyc;
        end

        // Content stage: registers {13'd0, pixel_xpos} (echo) or a constant colour.
        nxt_pd = echo_mode ? {13'd0, bus.pixel_xpos} : 24'hABCDEF;
        @(posedge lcd_pclk);
        bus.pixel_data = nxt_pd;
        if (rst_n) begin
            if (m_h == H_TOTAL - 1) begin
                m_h = 0;
                m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
        end
        cyc++;
        @(negedge lcd_pclk);
    endtask

    initial begin
        int n;
        if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT || V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT
            || H_BACK < 1 || H_TOTAL > 2047 || V_TOTAL > 2047) begin
            $display("FAIL param_constraints H_TOTAL=%0d V_TOTAL=%0d H_BACK=%0d", H_TOTAL, V_TOTAL, H_BACK);
            $fatal(1, "bad geometry");
        end

        bus.pixel_data = 24'h000000;
        bus.pattern_en = 1'b0;
        rst_n          = 1'b0;
        @(negedge lcd_pclk);

        // Reset state
        chk("rst_frame_start", 32'(bus.frame_start), 32'd1);
        chk("rst_lcd_hs",      32'(bus.lcd_hs),      32'd0);
        chk("rst_lcd_vs",      32'(bus.lcd_vs),      32'd0);
        chk("rst_lcd_rgb",     32'(bus.lcd_rgb),     32'd0);
        repeat (3) cycle();

        // Echo content: two full frames
        rst_n  = 1'b1;
        de_cnt = 0;
        repeat (FRAME) cycle();
        chk("de_per_frame", 32'(de_cnt), 32'(H_DISP * V_DISP));
        repeat (FRAME) cycle();
        chk("fs_interval", 32'(fs_last - fs_prev), 32'(FRAME));

        // Constant content colour
        echo_mode = 1'b0;
        repeat (FRAME) cycle();

        // Reset mid-frame at h=5, v=3
        n = 0;
        while (!(m_h == 5 && m_v == 3) && n < 2 * FRAME) begin
            cycle();
            n++;
        end
        chk("reach_h5_v3", 32'(m_h * 100 + m_v), 32'd503);
        rst_n = 1'b0;
        #1;
        m_h = 0;
        m_v = 0;
        sb.delete();
        chk("mid_rst_lcd_hs",      32'(bus.lcd_hs),      32'd0);
        chk("mid_rst_lcd_vs",      32'(bus.lcd_vs),      32'd0);
        chk("mid_rst_lcd_de",      32'(bus.lcd_de),      32'd0);
        chk("mid_rst_lcd_rgb",     32'(bus.lcd_rgb),     32'd0);
        chk("mid_rst_pixel_xpos",  32'(bus.pixel_xpos),  32'd0);
        chk("mid_rst_pixel_ypos",  32'(bus.pixel_ypos),  32'd0);
        chk("mid_rst_frame_start", 32'(bus.frame_start), 32'd1);
        repeat (3) cycle();
        rst_n = 1'b1;
        n = 0;
        while (!bus.lcd_de && n < 100) begin
            cycle();
            n++;
        end
        chk("first_de_latency", 32'(n), 32'(2 * H_TOTAL + HA));

        // Test pattern (ignored unless the pattern feature is built in)
        echo_mode = 1'b1;
        n = 0;
        while (!(m_h == 0 && m_v == 0) && n < 2 * FRAME) begin
            cycle();
            n++;
        end
        bus.pattern_en = 1'b1;
        repeat (FRAME) cycle();
        bus.pattern_en = 1'b0;
        repeat (H_TOTAL) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
